// File: rtl/uart_cmd_sequencer.sv
// Command-byte queue feeding UART_tx over trmt/tx_done, with inter-command gap and tx_done timeout.
// Optional macro SEQ_RETRY_EN: re-launch a timed-out byte up to MAX_RETRY times before flagging an error.
module uart_cmd_sequencer #(
   parameter int DATA_W         = 8,
   parameter int DEPTH          = 8,
   parameter int GAP_CYCLES     = 50,
   parameter int TIMEOUT_CYCLES = 10000000,
   parameter int MAX_RETRY      = 2
) (
   input  logic                       clk,
   input  logic                       RST,
   input  logic                       en,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       flush,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic [DATA_W-1:0]          tx_data,
   output logic                       trmt,
   input  logic                       tx_done,
   output logic                       busy,
   output logic                       timeout_err,
   input  logic                       clr_err,
   output logic [15:0]                sent_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam bit GAP_NONE = (GAP_CYCLES == 0);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_NONE ? 0 : GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1) ||
       (GAP_CYCLES < 0) || (MAX_RETRY < 0)) begin : g_param_check
      $error("uart_cmd_sequencer: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_GAP    = 3'd3,
      S_ERR    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                full_q, full_d;
   logic                empty_q, empty_d;
   logic                overflow_q, overflow_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic                trmt_q, trmt_d;
   logic                busy_q, busy_d;
   logic                timeout_err_q, timeout_err_d;
   logic [15:0]         sent_cnt_q, sent_cnt_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                pop_s;
   logic                push_acc_s;
   logic                to_set_s;
`ifdef SEQ_RETRY_EN
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
   logic [RETRY_W-1:0]  retry_q, retry_d;
`endif

   // Queue bookkeeping: a push is judged against the registered full flag, so a same-cycle pop never rescues it.
   always_comb begin
      pop_s      = (state_q == S_IDLE) && en && !empty_q;
      push_acc_s = push && !full_q && !flush;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (flush) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (push_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_acc_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
      full_d  = (count_d == CNT_FULL);
      empty_d = (count_d == {CNT_W{1'b0}});
      if (push && full_q) begin
         overflow_d = 1'b1;
      end else if (clr_err) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Sequencer next state: launch, wait for tx_done or timeout, then hold off for the gap.
   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      tmr_d      = tmr_q;
      gap_d      = gap_q;
      sent_cnt_d = sent_cnt_q;
      to_set_s   = 1'b0;
`ifdef SEQ_RETRY_EN
      retry_d    = retry_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (pop_s) begin
               tx_data_d = mem_q[rd_ptr_q];
               state_d   = S_LAUNCH;
`ifdef SEQ_RETRY_EN
               retry_d   = {RETRY_W{1'b0}};
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LAUNCH: begin
            tmr_d   = {TMR_W{1'b0}};
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tx_done) begin
               sent_cnt_d = sent_cnt_q + 16'd1;
`ifdef SEQ_RETRY_EN
               retry_d    = {RETRY_W{1'b0}};
`endif
               if (GAP_NONE) begin
                  state_d = S_IDLE;
               end else begin
                  gap_d   = GAP_LOAD;
                  state_d = S_GAP;
               end
            end else if (tmr_q == TMR_LAST) begin
`ifdef SEQ_RETRY_EN
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + RETRY_W'(1);
                  state_d = S_LAUNCH;
               end else begin
                  to_set_s = 1'b1;
                  state_d  = S_ERR;
               end
`else
               to_set_s = 1'b1;
               state_d  = S_ERR;
`endif
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_GAP: begin
            if (gap_q == {GAP_W{1'b0}}) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         S_ERR: begin
            if (clr_err) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (to_set_s) begin
         timeout_err_d = 1'b1;
      end else if (clr_err) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end
      trmt_d = (state_d == S_LAUNCH);
      busy_d = (state_d != S_IDLE);
   end

   // Queue storage; contents need no reset because occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push_acc_s) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // All control and status state, synchronously reset.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= {PTR_W{1'b0}};
         rd_ptr_q      <= {PTR_W{1'b0}};
         count_q       <= {CNT_W{1'b0}};
         full_q        <= 1'b0;
         empty_q       <= 1'b1;
         overflow_q    <= 1'b0;
         tx_data_q     <= {DATA_W{1'b0}};
         trmt_q        <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         sent_cnt_q    <= 16'd0;
         tmr_q         <= {TMR_W{1'b0}};
         gap_q         <= {GAP_W{1'b0}};
`ifdef SEQ_RETRY_EN
         retry_q       <= {RETRY_W{1'b0}};
`endif
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         full_q        <= full_d;
         empty_q       <= empty_d;
         overflow_q    <= overflow_d;
         tx_data_q     <= tx_data_d;
         trmt_q        <= trmt_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         sent_cnt_q    <= sent_cnt_d;
         tmr_q         <= tmr_d;
         gap_q         <= gap_d;
`ifdef SEQ_RETRY_EN
         retry_q       <= retry_d;
`endif
      end
   end

   assign full        = full_q;
   assign empty       = empty_q;
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign tx_data     = tx_data_q;
   assign trmt        = trmt_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;
   assign sent_cnt    = sent_cnt_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: latency, spacing, timeout, overflow/flush and reset abort.
module tb_uart_cmd_sequencer;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        en = 1'b0;
   logic        push = 1'b0;
   logic [7:0]  push_data = 8'h00;
   logic        flush = 1'b0;
   logic        full;
   logic        empty;
   logic [3:0]  count;
   logic        overflow;
   logic [7:0]  tx_data;
   logic        trmt;
   logic        tx_done = 1'b0;
   logic        busy;
   logic        timeout_err;
   logic        clr_err = 1'b0;
   logic [15:0] sent_cnt;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int resp_dly = 0;
   int dcnt = 0;
   int trmt_edge[$];
   logic [7:0] trmt_byte[$];

   uart_cmd_sequencer #(
      .DATA_W(8), .DEPTH(8), .GAP_CYCLES(50), .TIMEOUT_CYCLES(100), .MAX_RETRY(2)
   ) dut (
      .clk(clk), .RST(RST), .en(en), .push(push), .push_data(push_data), .flush(flush),
      .full(full), .empty(empty), .count(count), .overflow(overflow), .tx_data(tx_data),
      .trmt(trmt), .tx_done(tx_done), .busy(busy), .timeout_err(timeout_err),
      .clr_err(clr_err), .sent_cnt(sent_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // UART stand-in: logs each trmt cycle (as the edge that samples it) and answers with tx_done resp_dly edges later.
   initial begin
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (trmt === 1'b1) begin
            trmt_edge.push_back(cyc + 1);
            trmt_byte.push_back(tx_data);
         end
         if (trmt === 1'b1 && resp_dly > 0) begin
            dcnt = resp_dly;
         end else if (dcnt > 0) begin
            dcnt = dcnt - 1;
            if (dcnt == 0) tx_done = 1'b1;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] edge_at(input int i);
      if (i < trmt_edge.size()) return 64'(trmt_edge[i]);
      else return {64{1'b1}};
   endfunction

   function automatic logic [63:0] byte_at(input int i);
      if (i < trmt_byte.size()) return 64'(trmt_byte[i]);
      else return {64{1'b1}};
   endfunction

   task automatic wait_to(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      RST = 1'b1; push = 1'b0; flush = 1'b0; clr_err = 1'b0; dcnt = 0;
      repeat (2) @(posedge clk);
      #1;
      RST = 1'b0;
      trmt_edge.delete();
      trmt_byte.delete();
   endtask

   task automatic push_byte(input logic [7:0] b, output int edge_n);
      push = 1'b1;
      push_data = b;
      @(posedge clk);
      #1;
      push = 1'b0;
      edge_n = cyc;
   endtask

   int p, p2, t, t1, t2, t3, e, c, n_att;

   initial begin
      // Reset state and single-byte latency / gap.
      do_reset();
      check_eq("rst_count", 64'(count), 64'd0);
      check_eq("rst_empty", 64'(empty), 64'd1);
      check_eq("rst_full", 64'(full), 64'd0);
      check_eq("rst_flags", 64'({trmt, busy, timeout_err, overflow}), 64'd0);
      check_eq("rst_txdata", 64'(tx_data), 64'd0);
      check_eq("rst_sent", 64'(sent_cnt), 64'd0);
      en = 1'b1;
      resp_dly = 20;
      push_byte(8'h47, p);
      t = p + 2;
      wait_to(t + 1);
      en = 1'b0;
      wait_to(t + 19);
      check_eq("t1_sent_before", 64'(sent_cnt), 64'd0);
      wait_to(t + 20);
      check_eq("t1_sent_after", 64'(sent_cnt), 64'd1);
      wait_to(t + 69);
      check_eq("t1_busy_gap_end", 64'(busy), 64'd1);
      wait_to(t + 70);
      check_eq("t1_idle", 64'(busy), 64'd0);
      check_eq("t1_ntrmt", 64'(trmt_edge.size()), 64'd1);
      check_eq("t1_trmt_edge", edge_at(0), 64'(t));
      check_eq("t1_byte", byte_at(0), 64'h47);

      // Three back-to-back commands, 62-cycle spacing.
      do_reset();
      en = 1'b1;
      resp_dly = 10;
      push_byte(8'h47, p);
      push_byte(8'h53, p2);
      push_byte(8'h47, p2);
      t1 = p + 2; t2 = t1 + 62; t3 = t2 + 62;
      wait_to(t3 + 61);
      check_eq("t2_ntrmt", 64'(trmt_edge.size()), 64'd3);
      check_eq("t2_edge0", edge_at(0), 64'(t1));
      check_eq("t2_edge1", edge_at(1), 64'(t2));
      check_eq("t2_edge2", edge_at(2), 64'(t3));
      check_eq("t2_byte0", byte_at(0), 64'h47);
      check_eq("t2_byte1", byte_at(1), 64'h53);
      check_eq("t2_byte2", byte_at(2), 64'h47);
      check_eq("t2_sent", 64'(sent_cnt), 64'd3);
      check_eq("t2_empty", 64'(empty), 64'd1);
      check_eq("t2_busy", 64'(busy), 64'd0);

      // Timeout with tx_done withheld, then clr_err releases the next queued byte.
      do_reset();
      en = 1'b1;
      resp_dly = 0;
      push_byte(8'h53, p);
      push_byte(8'h47, p2);
      t = p + 2;
`ifdef SEQ_RETRY_EN
      e = t + 302;
      n_att = 3;
`else
      e = t + 100;
      n_att = 1;
`endif
      wait_to(e - 1);
      check_eq("t3_err_early", 64'(timeout_err), 64'd0);
      check_eq("t3_busy_wait", 64'(busy), 64'd1);
      wait_to(e);
      check_eq("t3_err_set", 64'(timeout_err), 64'd1);
      wait_to(e + 10);
      check_eq("t3_busy_err", 64'(busy), 64'd1);
      check_eq("t3_count_kept", 64'(count), 64'd1);
      check_eq("t3_ntrmt", 64'(trmt_edge.size()), 64'(n_att));
      check_eq("t3_first_edge", edge_at(0), 64'(t));
      check_eq("t3_last_byte", byte_at(n_att - 1), 64'h53);
`ifdef SEQ_RETRY_EN
      check_eq("t3_retry_edge1", edge_at(1), 64'(t + 101));
      check_eq("t3_retry_edge2", edge_at(2), 64'(t + 202));
      check_eq("t3_retry_byte1", byte_at(1), 64'h53);
`endif
      resp_dly = 5;
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      c = cyc;
      check_eq("t3_err_clr", 64'(timeout_err), 64'd0);
      wait_to(c + 60);
      check_eq("t3_next_edge", edge_at(n_att), 64'(c + 2));
      check_eq("t3_next_byte", byte_at(n_att), 64'h47);
      check_eq("t3_sent", 64'(sent_cnt), 64'd1);
      check_eq("t3_idle", 64'(busy), 64'd0);

`ifdef SEQ_RETRY_EN
      // Retry succeeding on the second attempt.
      do_reset();
      en = 1'b1;
      resp_dly = 0;
      push_byte(8'h47, p);
      t = p + 2;
      wait_to(t + 50);
      resp_dly = 10;
      wait_to(t + 170);
      check_eq("rt_ntrmt", 64'(trmt_edge.size()), 64'd2);
      check_eq("rt_edge1", edge_at(1), 64'(t + 101));
      check_eq("rt_byte1", byte_at(1), 64'h47);
      check_eq("rt_sent", 64'(sent_cnt), 64'd1);
      check_eq("rt_noerr", 64'(timeout_err), 64'd0);
`endif

      // Overflow with en low, clr_err outside ERR, flush and flush-over-push.
      do_reset();
      en = 1'b0;
      for (int i = 0; i < 9; i++) push_byte(8'(8'h10 + i), p);
      check_eq("ov_count", 64'(count), 64'd8);
      check_eq("ov_full", 64'(full), 64'd1);
      check_eq("ov_flag", 64'(overflow), 64'd1);
      check_eq("ov_notrmt", 64'(trmt_edge.size()), 64'd0);
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      check_eq("ov_clr", 64'(overflow), 64'd0);
      check_eq("ov_clr_count", 64'(count), 64'd8);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check_eq("fl_empty", 64'(empty), 64'd1);
      check_eq("fl_count", 64'(count), 64'd0);
      flush = 1'b1;
      push_byte(8'h99, p);
      flush = 1'b0;
      check_eq("fl_prio_count", 64'(count), 64'd0);
      check_eq("fl_prio_full", 64'(full), 64'd0);

      // Reset during WAIT_DONE aborts the transfer.
      do_reset();
      en = 1'b1;
      resp_dly = 0;
      push_byte(8'h47, p);
      push_byte(8'h53, p2);
      t = p + 2;
      wait_to(t + 5);
      RST = 1'b1;
      @(posedge clk);
      #1;
      RST = 1'b0;
      check_eq("ra_trmt", 64'(trmt), 64'd0);
      check_eq("ra_busy", 64'(busy), 64'd0);
      check_eq("ra_count", 64'(count), 64'd0);
      check_eq("ra_sent", 64'(sent_cnt), 64'd0);
      repeat (30) @(posedge clk);
      #1;
      check_eq("ra_ntrmt", 64'(trmt_edge.size()), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
Hardware command sequencer that queues command bytes such as 'G' (0x47) and 'S' (0x53) and feeds them to the UART transmitter through its trmt/tx_done handshake. After each byte it waits a programmable inter-command gap, and it flags a timeout if tx_done never returns. It sits between a host or stimulus source and UART_tx in Segway bring-up and self-test builds. It generalises the single-byte send to a DEPTH-entry queue with gap, timeout and status tracking.

Parameters:
DATA_W, 8, command byte width
DEPTH, 8, queue entries; power of 2, ≥2
GAP_CYCLES, 50, idle clocks after tx_done before next trmt; 0 allowed
TIMEOUT_CYCLES, 10000000, clocks to wait for tx_done before error; ≥1
MAX_RETRY, 2, resend attempts after a timeout (used only with SEQ_RETRY_EN)

Ports:
clk  in  1  system clock
RST  in  1  synchronous active-high reset
en  in  1  sequencer enable; when low, no new byte is launched
push  in  1  enqueue push_data this cycle
push_data  in  DATA_W  command byte
flush  in  1  empty the queue
full  out  1  queue full
empty  out  1  queue empty
count  out  $clog2(DEPTH+1)  queue occupancy
overflow  out  1  sticky: push attempted while full
tx_data  out  DATA_W  byte to UART_tx
trmt  out  1  one-cycle transmit strobe
tx_done  in  1  UART_tx completion (level or pulse)
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky timeout flag
clr_err  in  1  clears timeout_err and overflow; exits ERR
sent_cnt  out  16  bytes completed; wraps at 0xFFFF→0

Behaviour:
- Reset: clock is clk; reset is RST, synchronous, active-high.
  - Queue empties; count=0, empty=1, full=0.
  - tx_data=0, trmt=0, busy=0, timeout_err=0, overflow=0, sent_cnt=0.
  - FSM returns to IDLE.
  - Reset mid-transfer aborts the transfer with no trmt re-issue.
- Queue (FIFO, registered pointers):
  - A push is accepted only when full=0 at that edge.
  - A push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full queue leaves count unchanged.
  - flush has priority over push in the same cycle.
  - flush empties the queue only; an in-flight byte completes normally.
- FSM states: IDLE, LAUNCH, WAIT_DONE, GAP, ERR.
  - IDLE: when en=1 and empty=0, pop the head into tx_data → LAUNCH.
  - LAUNCH: trmt=1 for exactly this cycle; clear the timeout counter → WAIT_DONE.
  - WAIT_DONE: increment the timeout counter each cycle. tx_done=1 → sent_cnt+1, load the gap counter → GAP (or IDLE if GAP_CYCLES=0).
  - WAIT_DONE timeout: when the counter reaches TIMEOUT_CYCLES-1 with tx_done=0, set timeout_err → ERR.
  - WAIT_DONE priority: tx_done wins over a timeout in the same cycle.
  - GAP: count down GAP_CYCLES clocks → IDLE. tx_done is ignored in this state.
  - ERR: busy=1; no launches; queue is retained and pushes are still accepted. clr_err=1 → IDLE.
- clr_err outside ERR clears only the flags; the FSM is unaffected.
- Latency:
  - A push into an empty queue at edge N (en=1, IDLE) gives trmt high in cycle N+2.
  - Back-to-back bytes: trmt-to-trmt spacing is (cycles to tx_done) + GAP_CYCLES + 2.
- en dropping mid-transfer never aborts the transfer; it only blocks the next launch from IDLE.
- tx_data holds its value from LAUNCH until the next pop.

Optional Feature:
Macro: SEQ_RETRY_EN
- Defined:
  - On a timeout, if the retry count is below MAX_RETRY, increment the retry count, re-pulse trmt with the same tx_data via LAUNCH, and stay out of ERR.
  - timeout_err sets only after MAX_RETRY+1 total failed attempts.
  - The retry count clears on every successful tx_done and on every pop.
- Undefined:
  - The first timeout goes directly to ERR.
  - No retry logic is synthesised.

Test Plan:
- Reset, then push 0x47 with en=1 and tx_done pulsed 20 cycles after trmt → trmt pulses once in cycle N+2 with tx_data=0x47. Then sent_cnt=1, busy for 50 cycles after tx_done, then IDLE.
- Push 0x47, 0x53, 0x47 back-to-back with tx_done returned after 10 cycles → three single-cycle trmt pulses, each spaced 62 cycles, in order 47/53/47. Final state: sent_cnt=3, empty=1.
- TIMEOUT_CYCLES=100 with tx_done held low → timeout_err=1 at cycle 100 after trmt and busy stays 1. clr_err → IDLE and the next queued byte launches.
- Push 9 bytes with en=0 and DEPTH=8 → full=1, count=8, overflow=1, ninth byte dropped. flush → empty=1, count=0.
- SEQ_RETRY_EN, MAX_RETRY=2, TIMEOUT_CYCLES=100, tx_done withheld → three trmt pulses with identical tx_data, then timeout_err=1. Rerun with tx_done on the 2nd attempt → no error and sent_cnt=1.
- Assert RST during WAIT_DONE → next cycle: trmt=0, busy=0, count=0, sent_cnt=0, and no trmt afterwards.
